// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave backed by a word-addressed RAM, with a fixed
// response latency and a cap on accepted-but-unanswered requests.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif

module wb_mem_slave #(
    parameter int unsigned ADDR_WIDTH      = `CORE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = `CORE_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_rty_o
);
    localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANES  = 4;

    typedef struct packed {
        logic                  ack;
        logic                  err;
        logic [DATA_WIDTH-1:0] dat;
    } stage_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    stage_t                pipe [LATENCY];
    stage_t                entry;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  stall_q;
    logic [WIDX_W-1:0]     word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  oor;
    logic                  acc;
    logic                  done;
    logic                  flush;
    logic                  unused_adr_lsb;

    assign word_idx       = wb_adr_i[ADDR_WIDTH-1:2];
    assign mem_idx        = word_idx[MEM_AW-1:0];
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // Depth is a power of two, so any set bit above the RAM index is out of range.
    if (WIDX_W > MEM_AW) begin : g_range
        assign oor = |word_idx[WIDX_W-1:MEM_AW];
    end else begin : g_no_range
        assign oor = 1'b0;
    end

    assign flush = wb_rst_i | ~wb_cyc_i;
    assign acc   = wb_cyc_i & wb_stb_i & ~stall_q & ~wb_rst_i;
    assign done  = pipe[LATENCY-1].ack | pipe[LATENCY-1].err;

    // Response entering the pipeline; data is zero unless it is an in-range read.
    always_comb begin
        entry     = '0;
        entry.ack = acc & ~oor;
        entry.err = acc & oor;
        if (acc && !oor && !wb_we_i) begin
            entry.dat = mem[mem_idx];
        end
    end

    always_comb begin
        cnt_next = cnt;
        if (flush) begin
            cnt_next = '0;
        end else if (acc && !done) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!acc && done) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Reset and bus abort both drop every in-flight response.
    always_ff @(posedge wb_clk_i) begin
        if (flush) begin
            cnt     <= '0;
            stall_q <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            cnt     <= cnt_next;
            stall_q <= (cnt_next == CNT_W'(MAX_OUTSTANDING));
            pipe[0] <= entry;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // RAM has no reset so that contents survive a bus reset.
    always_ff @(posedge wb_clk_i) begin
        if (acc && wb_we_i && !oor) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wb_sel_i[i]) begin
                    mem[mem_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign wb_stall_o = stall_q;
    assign wb_ack_o   = pipe[LATENCY-1].ack;
    assign wb_err_o   = pipe[LATENCY-1].err;
    assign wb_dat_o   = pipe[LATENCY-1].dat;
    assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: four instances with different latency/outstanding
// settings, checked cycle by cycle against a transaction-level model.
module tb_wb_mem_slave;
    localparam int unsigned NDUT  = 4;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT  [NDUT] = '{2, 4, 3, 1};
    localparam int unsigned MAXO [NDUT] = '{4, 2, 4, 1};
    localparam int BUDGET = 3000;

    typedef struct packed {
        logic        stall;
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } obs_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        int unsigned due;
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } resp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [31:0]     adr;
    logic [31:0]     wdat;
    logic [3:0]      sel;
    logic [NDUT-1:0] stall_v;
    logic [NDUT-1:0] ack_v;
    logic [NDUT-1:0] err_v;
    logic [NDUT-1:0] rty_v;
    logic [31:0]     rdat_v [NDUT];
    int unsigned     dsel;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        wb_mem_slave #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
            .LATENCY(LAT[k]), .MAX_OUTSTANDING(MAXO[k])
        ) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_i  (rst),
            .wb_cyc_i  (cyc && (dsel == k)),
            .wb_stb_i  (stb),
            .wb_we_i   (we),
            .wb_adr_i  (adr),
            .wb_dat_i  (wdat),
            .wb_sel_i  (sel),
            .wb_stall_o(stall_v[k]),
            .wb_ack_o  (ack_v[k]),
            .wb_err_o  (err_v[k]),
            .wb_dat_o  (rdat_v[k]),
            .wb_rty_o  (rty_v[k])
        );
    end

    // Transaction-level model: memory image per instance plus in-order response list.
    logic [31:0] ref_mem [NDUT][DEPTH];
    req_t        req_q [$];
    resp_t       pend [$];
    int unsigned edge_n;
    logic        m_stall;
    bit          gaps;
    int          n_cmp;
    int          n_err;
    int          acks;
    int          errs;
    bit          saw_stall;
    logic [31:0] last_rd;

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.we = 1'b1; r.adr = a; r.dat = d; r.sel = s;
        req_q.push_back(r);
    endtask

    task automatic push_rd(input logic [31:0] a);
        req_t r;
        r.we = 1'b0; r.adr = a; r.dat = $urandom(); r.sel = 4'($urandom());
        req_q.push_back(r);
    endtask

    task automatic drive_next();
        if (req_q.size() != 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
            stb = 1'b1; we = req_q[0].we; adr = req_q[0].adr;
            wdat = req_q[0].dat; sel = req_q[0].sel;
        end else begin
            stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
        end
    endtask

    // One clock: apply the model's view of the edge, then sample the selected DUT.
    task automatic bus_cycle(output obs_t got, output obs_t exp);
        bit          acc;
        req_t        r;
        resp_t       p;
        int unsigned idx;
        acc = cyc && stb && !m_stall && !rst;
        @(posedge clk);
        edge_n++;
        if (rst || !cyc) begin
            pend.delete();
        end else begin
            while (pend.size() != 0 && pend[0].due < edge_n) void'(pend.pop_front());
            if (acc) begin
                r     = req_q.pop_front();
                idx   = 32'(r.adr[31:2]);
                p.due = edge_n + LAT[dsel] - 1;
                p.err = (idx >= DEPTH);
                p.rd  = !r.we;
                p.dat = '0;
                if (!p.err && r.we) begin
                    for (int i = 0; i < 4; i++)
                        if (r.sel[i]) ref_mem[dsel][idx][8*i +: 8] = r.dat[8*i +: 8];
                end else if (!p.err) begin
                    p.dat = ref_mem[dsel][idx];
                end
                pend.push_back(p);
            end
        end
        exp.stall = (pend.size() == MAXO[dsel]);
        exp.ack   = (pend.size() != 0) && (pend[0].due == edge_n) && !pend[0].err;
        exp.err   = (pend.size() != 0) && (pend[0].due == edge_n) && pend[0].err;
        exp.dat   = exp.ack ? pend[0].dat : 32'h0;
        m_stall   = exp.stall;
        #1;
        got.stall = stall_v[dsel];
        got.ack   = ack_v[dsel];
        got.err   = err_v[dsel];
        got.dat   = rdat_v[dsel];
        if (got.ack) acks++;
        if (got.err) errs++;
        if (got.stall) saw_stall = 1'b1;
        if (got.ack && exp.ack && pend[0].rd) last_rd = got.dat;
        drive_next();
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b1; cyc = 1'b0;
        repeat (3) bus_cycle(got, exp);
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++;
            if ({stall_v[k], ack_v[k], err_v[k], rty_v[k], rdat_v[k]} !== 36'h0) begin
                n_err++;
                $display("FAIL reset dut%0d got stall=%b ack=%b err=%b rty=%b dat=%h want all 0",
                         k, stall_v[k], ack_v[k], err_v[k], rty_v[k], rdat_v[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        obs_t got, exp;
        int   n;
        dsel = 0; cyc = 1'b1; acks = 0; errs = 0;
        push_wr(32'h10, 32'hDEADBEEF, 4'hF);
        push_rd(32'h10);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL single edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || acks != 2 || errs != 0 || last_rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_summary acks=%0d errs=%0d rd=%h want 2/0/deadbeef", acks, errs, last_rd);
        end
    endtask

    task automatic test_byte_lanes();
        obs_t got, exp;
        int   n;
        dsel = 0; cyc = 1'b1;
        push_wr(32'h20, 32'h11223344, 4'hF);
        push_wr(32'h20, 32'hAABBCCDD, 4'b0101);
        push_rd(32'h20);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL lanes edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || last_rd !== 32'h11BB33DD) begin
            n_err++; $display("FAIL lanes_readback got=%h want=11bb33dd", last_rd);
        end
    endtask

    task automatic test_stream();
        obs_t got, exp;
        int   n;
        dsel = 1; cyc = 1'b1;
        for (int i = 0; i < 6; i++) push_wr(32'(i * 4), $urandom(), 4'hF);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL stream_wr edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        acks = 0; saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) push_rd(32'(i * 4));
        drive_next();
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL stream_rd edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || acks != 6 || !saw_stall) begin
            n_err++; $display("FAIL stream_summary acks=%0d stall_seen=%b want 6/1", acks, saw_stall);
        end
    endtask

    task automatic test_out_of_range();
        obs_t got, exp;
        int   n;
        dsel = 0; cyc = 1'b1; acks = 0; errs = 0;
        push_wr(32'h0, 32'h5A5AA5A5, 4'hF);
        push_rd(32'h1000);
        push_wr(32'h1000, 32'hFFFFFFFF, 4'hF);
        push_rd(32'h0);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL range edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || errs != 2 || acks != 2 || last_rd !== 32'h5A5AA5A5) begin
            n_err++;
            $display("FAIL range_summary errs=%0d acks=%0d rd=%h want 2/2/5a5aa5a5", errs, acks, last_rd);
        end
    endtask

    task automatic test_abort();
        obs_t        got, exp;
        int          n;
        logic [31:0] v;
        dsel = 2; cyc = 1'b1; v = $urandom();
        push_wr(32'h8, v, 4'hF);
        push_rd(32'h8);
        drive_next();
        repeat (2) begin
            bus_cycle(got, exp); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL abort_issue edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        cyc = 1'b0; acks = 0; errs = 0;
        repeat (5) begin
            bus_cycle(got, exp); n_cmp++;
            if (got !== 35'h0) begin
                n_err++; $display("FAIL abort_quiet edge%0d got=%h want=0", edge_n, got);
            end
        end
        n_cmp++;
        if (acks != 0 || errs != 0) begin
            n_err++; $display("FAIL abort_count acks=%0d errs=%0d want 0/0", acks, errs);
        end
        cyc = 1'b1;
        push_rd(32'h8);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL abort_reread edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || last_rd !== v) begin
            n_err++; $display("FAIL abort_data got=%h want=%h", last_rd, v);
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        int   n;
        dsel = 0; cyc = 1'b1;
        push_rd(32'h10);
        push_rd(32'h20);
        drive_next();
        repeat (2) begin
            bus_cycle(got, exp); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL rstmid_issue edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        rst = 1'b1; req_q.delete(); drive_next();
        bus_cycle(got, exp); n_cmp++;
        if (got !== 35'h0) begin
            n_err++; $display("FAIL rstmid_outputs got=%h want=0", got);
        end
        rst = 1'b0; acks = 0; errs = 0;
        repeat (4) bus_cycle(got, exp);
        n_cmp++;
        if (acks != 0 || errs != 0) begin
            n_err++; $display("FAIL rstmid_stale acks=%0d errs=%0d want 0/0", acks, errs);
        end
        push_rd(32'h10);
        push_rd(32'h20);
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL rstmid_reread edge%0d got=%h want=%h", edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || last_rd !== 32'h11BB33DD) begin
            n_err++; $display("FAIL rstmid_data got=%h want=11bb33dd", last_rd);
        end
    endtask

    task automatic test_random(input int unsigned d);
        obs_t        got, exp;
        int          n;
        int          total;
        int unsigned base;
        int unsigned w;
        int unsigned kind;
        dsel = d; cyc = 1'b1; gaps = 1'b1; acks = 0; errs = 0;
        base = $urandom_range(64, DEPTH - 16);
        for (int i = 0; i < 16; i++) push_wr(32'((base + i) * 4), $urandom(), 4'hF);
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            w    = base + $urandom_range(0, 15);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 1) push_wr(32'h1000 | ($urandom() & 32'h00FF_FFFC), $urandom(), 4'hF);
                else push_rd(32'h1000 | ($urandom() & 32'h00FF_FFFC));
            end else if (kind < 5) begin
                push_wr(32'(w * 4) | 32'($urandom_range(0, 3)), $urandom(), 4'($urandom()));
            end else begin
                push_rd(32'(w * 4) | 32'($urandom_range(0, 3)));
            end
        end
        total = req_q.size();
        drive_next();
        n = 0;
        while ((req_q.size() != 0 || pend.size() != 0) && n < BUDGET) begin
            bus_cycle(got, exp); n++; n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL random dut%0d edge%0d got=%h want=%h", d, edge_n, got, exp);
            end
        end
        n_cmp++;
        if (n >= BUDGET || acks + errs != total) begin
            n_err++; $display("FAIL random_count dut%0d responses=%0d want %0d", d, acks + errs, total);
        end
        gaps = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
        dsel = 0; m_stall = 1'b0; edge_n = 0; gaps = 1'b0;
        n_cmp = 0; n_err = 0; acks = 0; errs = 0; saw_stall = 1'b0; last_rd = '0;
        test_reset();
        test_single();
        test_byte_lanes();
        test_stream();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_random(3);
        test_random(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
